pipelined_subtractor: RTL and testbench

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

---
 rtl/pipelined_subtractor.sv | 100 ++++++++++
 tb/tb_pipelined_subtractor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_subtractor
// Brief   : Two-stage valid/ready subtractor (A - B) with borrow flag and
//           delivered-result / borrow statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] borrow_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CNT_W-1:0] r_txn_count;
    logic [CNT_W-1:0] r_borrow_count;

    logic             w_s2_load;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH:0]   w_sub;

    // in_ready depends only on pipeline state and out_ready, never on in_valid
    assign w_s2_load  = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    // Zero-extended subtraction: the extra MSB is the unsigned borrow
    assign w_sub = {1'b0, r_s1_a} - {1'b0, r_s1_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= A;
            r_s1_b     <= B;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff   <= w_sub[WIDTH-1:0];
                r_borrow <= w_sub[WIDTH];
            end
        end
    end

    // txn_count wraps naturally; borrow_count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count    <= '0;
            r_borrow_count <= '0;
        end else if (w_out_fire) begin
            r_txn_count <= r_txn_count + C_CNT_ONE;
            if (r_borrow && (r_borrow_count != C_CNT_MAX)) begin
                r_borrow_count <= r_borrow_count + C_CNT_ONE;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign diff         = r_diff;
    assign borrow       = r_borrow;
    assign txn_count    = r_txn_count;
    assign borrow_count = r_borrow_count;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_subtractor.sv
`default_nettype none
// Testbench for pipelined_subtractor: randomized traffic against a queue model,
// plus directed latency, wrap, backpressure, counter and reset scenarios.
module tb_pipelined_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  diff;
    logic        borrow;
    logic [15:0] txn_count;
    logic [15:0] borrow_count;

    // Narrow-counter instance sharing the same stimulus, used for wrap/saturation
    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_diff;
    logic        s_borrow;
    logic [3:0]  s_txn;
    logic [3:0]  s_bcnt;

    pipelined_subtractor #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .txn_count(txn_count), .borrow_count(borrow_count)
    );

    pipelined_subtractor #(.WIDTH(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(A), .B(B), .out_valid(s_out_valid), .out_ready(out_ready),
        .diff(s_diff), .borrow(s_borrow), .txn_count(s_txn), .borrow_count(s_bcnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: in-flight results in acceptance order, plus counters
    logic [8:0] q[$];
    int exp_txn  = 0;
    int exp_bcnt = 0;

    logic       ovld, fire, irdy;
    logic [8:0] got, expv, got_s;
    int         occ;

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        q.delete(); exp_txn = 0; exp_bcnt = 0;
    endtask

    // One clock: drive at negedge, observe 1 time unit later, update the model
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ordy);
        logic [7:0] d;
        in_valid = v; A = a; B = b; out_ready = ordy;
        #1;
        occ   = q.size();
        ovld  = out_valid;
        irdy  = in_ready;
        got   = {borrow, diff};
        got_s = {s_borrow, s_diff};
        fire  = out_valid && ordy;
        expv  = 9'bx;
        if (fire) begin
            if (q.size() > 0) expv = q.pop_front();
            exp_txn = (exp_txn + 1) % 65536;
            if (expv[8] === 1'b1 && exp_bcnt < 65535) exp_bcnt++;
        end
        if (v && in_ready) begin
            d = a - b;
            q.push_back({(a < b), d});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if ({borrow, diff} !== 9'h000) $display("FAIL reset_result: got %h expected 000", {borrow, diff}); else n_pass++;
        n_checks++; if (txn_count !== 16'h0) $display("FAIL reset_txn: got %h expected 0000", txn_count); else n_pass++;
        n_checks++; if (borrow_count !== 16'h0) $display("FAIL reset_bcnt: got %h expected 0000", borrow_count); else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        q.delete(); exp_txn = 0; exp_bcnt = 0;
    endtask

    task automatic test_basic_latency();
        do_reset();
        step(1'b1, 8'h05, 8'h03, 1'b1);
        n_checks++; if (irdy !== 1'b1) $display("FAIL first_accept_ready: got %b expected 1", irdy); else n_pass++;
        step(1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++; if (ovld !== 1'b0) $display("FAIL latency_early: got out_valid %b expected 0", ovld); else n_pass++;
        step(1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++; if (ovld !== 1'b1) $display("FAIL latency_2: got out_valid %b expected 1", ovld); else n_pass++;
        n_checks++; if (got !== 9'h002) $display("FAIL basic_result: got %h expected 002", got); else n_pass++;
        step(1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++; if (ovld !== 1'b0) $display("FAIL single_pulse: got out_valid %b expected 0", ovld); else n_pass++;
        n_checks++; if (txn_count !== 16'd1) $display("FAIL basic_txn: got %0d expected 1", txn_count); else n_pass++;
    endtask

    task automatic test_borrow_wrap();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      step(1'b1, 8'h00, 8'h01, 1'b1);
            else if (c == 1) step(1'b1, 8'h80, 8'h80, 1'b1);
            else             step(1'b0, 8'h00, 8'h00, 1'b1);
            if (fire) begin
                n_checks++;
                if (k == 0 && got !== 9'h1FF) $display("FAIL wrap_underflow: got %h expected 1ff", got);
                else if (k == 1 && got !== 9'h000) $display("FAIL wrap_equal: got %h expected 000", got);
                else n_pass++;
                k++;
            end
        end
        n_checks++; if (k !== 2) $display("FAIL wrap_count: got %0d results expected 2", k); else n_pass++;
        n_checks++; if (borrow_count !== 16'd1) $display("FAIL wrap_bcnt: got %0d expected 1", borrow_count); else n_pass++;
        n_checks++; if (txn_count !== 16'd2) $display("FAIL wrap_txn: got %0d expected 2", txn_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first, nres;
        do_reset();
        first = -1; nres = 0;
        for (int c = 0; c < 14; c++) begin
            step(c < 10, 8'($urandom), 8'($urandom), 1'b1);
            if (fire) begin
                if (first < 0) first = c;
                n_checks++; if (got !== expv) $display("FAIL b2b_data: got %h expected %h", got, expv); else n_pass++;
                n_checks++; if (c !== first + nres) $display("FAIL b2b_gap: got cycle %0d expected %0d", c, first + nres); else n_pass++;
                nres++;
            end
        end
        n_checks++; if (nres !== 10) $display("FAIL b2b_count: got %0d expected 10", nres); else n_pass++;
        n_checks++; if (first !== 2) $display("FAIL b2b_latency: got first at %0d expected 2", first); else n_pass++;
        n_checks++; if (txn_count !== 16'd10) $display("FAIL b2b_txn: got %0d expected 10", txn_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int acc, nres;
        logic       held_seen;
        logic [8:0] held;
        do_reset();
        acc = 0; held_seen = 1'b0; held = 9'h0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
            if (irdy) acc++;
            if (ovld && !held_seen) begin
                held_seen = 1'b1;
                held = got;
            end else if (held_seen) begin
                n_checks++;
                if (ovld !== 1'b1 || got !== held) $display("FAIL bp_stable: got %b/%h expected 1/%h", ovld, got, held);
                else n_pass++;
            end
        end
        n_checks++; if (acc !== 2) $display("FAIL bp_accepted: got %0d expected 2", acc); else n_pass++;
        n_checks++; if (irdy !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", irdy); else n_pass++;
        nres = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1);
            if (fire) begin
                nres++;
                n_checks++; if (got !== expv) $display("FAIL bp_order: got %h expected %h", got, expv); else n_pass++;
            end
        end
        n_checks++; if (nres !== 2) $display("FAIL bp_drained: got %0d expected 2", nres); else n_pass++;
        n_checks++; if (txn_count !== 16'd2) $display("FAIL bp_txn: got %0d expected 2", txn_count); else n_pass++;
    endtask

    task automatic test_random();
        logic       p_ovld, p_ordy, ordy;
        logic [8:0] p_got;
        do_reset();
        p_ovld = 1'b0; p_ordy = 1'b1; p_got = 9'h0;
        for (int c = 0; c < 400; c++) begin
            ordy = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), ordy);
            n_checks++;
            if (irdy !== ((occ < 2) || ordy)) $display("FAIL rnd_in_ready: got %b expected %b (occ %0d)", irdy, (occ < 2) || ordy, occ);
            else n_pass++;
            if (fire) begin
                n_checks++; if (got !== expv) $display("FAIL rnd_data: got %h expected %h", got, expv); else n_pass++;
            end
            if (p_ovld && !p_ordy) begin
                n_checks++;
                if (ovld !== 1'b1 || got !== p_got) $display("FAIL rnd_hold: got %b/%h expected 1/%h", ovld, got, p_got);
                else n_pass++;
            end
            p_ovld = ovld; p_ordy = ordy; p_got = got;
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1);
            if (fire) begin
                n_checks++; if (got !== expv) $display("FAIL rnd_drain: got %h expected %h", got, expv); else n_pass++;
            end
        end
        n_checks++; if (q.size() !== 0) $display("FAIL rnd_lost: got %0d pending expected 0", q.size()); else n_pass++;
        n_checks++; if (txn_count !== 16'(exp_txn)) $display("FAIL rnd_txn: got %0d expected %0d", txn_count, exp_txn); else n_pass++;
        n_checks++; if (borrow_count !== 16'(exp_bcnt)) $display("FAIL rnd_bcnt: got %0d expected %0d", borrow_count, exp_bcnt); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        logic [7:0] a;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < ((r == 0) ? 15 : 1); c++) begin
                a = 8'($urandom_range(0, 100));
                step(1'b1, a, a + 8'($urandom_range(1, 100)), 1'b1);
                if (fire) begin
                    n_checks++; if (got_s !== expv) $display("FAIL cnt_data: got %h expected %h", got_s, expv); else n_pass++;
                end
            end
            for (int c = 0; c < 3; c++) begin
                step(1'b0, 8'h00, 8'h00, 1'b1);
                if (fire) begin
                    n_checks++; if (got_s !== expv) $display("FAIL cnt_data: got %h expected %h", got_s, expv); else n_pass++;
                end
            end
            n_checks++; if (s_txn !== 4'(exp_txn % 16)) $display("FAIL cnt_txn_wrap: got %0d expected %0d", s_txn, exp_txn % 16); else n_pass++;
            n_checks++;
            if (s_bcnt !== 4'((exp_bcnt > 15) ? 15 : exp_bcnt)) $display("FAIL cnt_bcnt_sat: got %0d expected %0d", s_bcnt, (exp_bcnt > 15) ? 15 : exp_bcnt);
            else n_pass++;
            n_checks++; if (txn_count !== 16'(exp_txn)) $display("FAIL cnt_txn_main: got %0d expected %0d", txn_count, exp_txn); else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        int nres;
        do_reset();
        step(1'b1, 8'h03, 8'h09, 1'b1);
        step(1'b1, 8'h07, 8'h07, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'h44, 8'h22, 1'b0);
        step(1'b1, 8'h55, 8'h66, 1'b0);
        n_checks++; if (txn_count !== 16'd2) $display("FAIL mid_pre_txn: got %0d expected 2", txn_count); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (txn_count !== 16'd0) $display("FAIL mid_txn: got %0d expected 0", txn_count); else n_pass++;
        n_checks++; if (borrow_count !== 16'd0) $display("FAIL mid_bcnt: got %0d expected 0", borrow_count); else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete(); exp_txn = 0; exp_bcnt = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1);
            n_checks++; if (ovld !== 1'b0) $display("FAIL mid_stale: got out_valid %b expected 0", ovld); else n_pass++;
        end
        nres = 0;
        for (int c = 0; c < 4; c++) begin
            step(c == 0, 8'h33, 8'h11, 1'b1);
            if (fire) begin
                nres++;
                n_checks++; if (got !== expv) $display("FAIL mid_new: got %h expected %h", got, expv); else n_pass++;
            end
        end
        n_checks++; if (nres !== 1) $display("FAIL mid_new_count: got %0d expected 1", nres); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_borrow_wrap();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_counter_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
